// File: rtl/pipe_hazard_sched_if.sv
// pipe_hazard_sched_if
//   Bundles the pipeline-side signals of the hazard scheduler.
//   master : pipeline datapath (drives ID/EX/MEM/WB status, receives controls)
//   slave  : the scheduler itself
//   Status  : id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_is_md,
//             ex_rd, ex_mem_read, mem_rd, mem_reg_write, wb_rd, wb_reg_write,
//             br_taken, md_done
//   Control : stall_if, stall_id, bubble_ex, flush_if, flush_id, fwd_a, fwd_b,
//             md_start, md_abort, stall_cnt, flush_cnt
interface pipe_hazard_sched_if;
   logic        id_valid;
   logic [4:0]  id_rs1;
   logic [4:0]  id_rs2;
   logic        id_use_rs1;
   logic        id_use_rs2;
   logic        id_is_md;
   logic [4:0]  ex_rd;
   logic        ex_mem_read;
   logic [4:0]  mem_rd;
   logic        mem_reg_write;
   logic [4:0]  wb_rd;
   logic        wb_reg_write;
   logic        br_taken;
   logic        md_done;
   logic        stall_if;
   logic        stall_id;
   logic        bubble_ex;
   logic        flush_if;
   logic        flush_id;
   logic [1:0]  fwd_a;
   logic [1:0]  fwd_b;
   logic        md_start;
   logic        md_abort;
   logic [31:0] stall_cnt;
   logic [31:0] flush_cnt;

   modport master (
      output id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_is_md,
             ex_rd, ex_mem_read, mem_rd, mem_reg_write, wb_rd, wb_reg_write,
             br_taken, md_done,
      input  stall_if, stall_id, bubble_ex, flush_if, flush_id, fwd_a, fwd_b,
             md_start, md_abort, stall_cnt, flush_cnt
   );

   modport slave (
      input  id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_is_md,
             ex_rd, ex_mem_read, mem_rd, mem_reg_write, wb_rd, wb_reg_write,
             br_taken, md_done,
      output stall_if, stall_id, bubble_ex, flush_if, flush_id, fwd_a, fwd_b,
             md_start, md_abort, stall_cnt, flush_cnt
   );
endinterface

// File: rtl/pipe_hazard_sched.sv
// pipe_hazard_sched
//   Stall/flush/forward scheduler for the 5-stage RV32 pipeline. Generates
//   IF/ID hold, EX bubbles, IF/ID and ID/EX squash, EX operand forwarding
//   selects and the MUL/DIV start/abort handshake, plus saturating stall and
//   flush cycle counters.
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset
//   hz   : scheduler side of pipe_hazard_sched_if (all status in, controls out)
//   FLUSH_LEN  : cycles flush_if stays high per taken branch (1..15)
//   MD_TIMEOUT : MD_BUSY cycles before a forced md_abort (2..255)
module pipe_hazard_sched #(
   parameter int unsigned FLUSH_LEN  = 1,
   parameter int unsigned MD_TIMEOUT = 64
) (
   input  logic                 clk,
   input  logic                 rst,
   pipe_hazard_sched_if.slave   hz
);

   typedef enum logic [1:0] {
      RUN     = 2'd0,
      FLUSH   = 2'd1,
      MD_BUSY = 2'd2
   } state_t;

   localparam logic [7:0] FLUSH_INIT = 8'(FLUSH_LEN - 1);
   localparam logic [7:0] MD_LAST    = 8'(MD_TIMEOUT - 1);

   state_t      state, state_nx;
   logic [7:0]  cnt, cnt_nx;
   logic [31:0] stall_cnt, flush_cnt;
   logic        load_use;
   logic        stall_if, stall_id, bubble_ex, flush_if, flush_id;
   logic        md_start, md_abort;

   // MEM result is younger than WB, so it takes precedence.
   function automatic logic [1:0] fwd_sel(
      input logic [4:0] rs,
      input logic [4:0] mem_rd,
      input logic       mem_we,
      input logic [4:0] wb_rd,
      input logic       wb_we
   );
      if (mem_we && (mem_rd != 5'd0) && (mem_rd == rs))
         return 2'b10;
      else if (wb_we && (wb_rd != 5'd0) && (wb_rd == rs))
         return 2'b01;
      else
         return 2'b00;
   endfunction

   assign hz.fwd_a = fwd_sel(hz.id_rs1, hz.mem_rd, hz.mem_reg_write,
                             hz.wb_rd, hz.wb_reg_write);
   assign hz.fwd_b = fwd_sel(hz.id_rs2, hz.mem_rd, hz.mem_reg_write,
                             hz.wb_rd, hz.wb_reg_write);

   assign load_use = hz.id_valid && hz.ex_mem_read && (hz.ex_rd != 5'd0) &&
                     ((hz.id_use_rs1 && (hz.ex_rd == hz.id_rs1)) ||
                      (hz.id_use_rs2 && (hz.ex_rd == hz.id_rs2)));

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= RUN;
         cnt   <= '0;
      end else begin
         state <= state_nx;
         cnt   <= cnt_nx;
      end
   end

   always_comb begin
      state_nx  = state;
      cnt_nx    = cnt;
      stall_if  = 1'b0;
      stall_id  = 1'b0;
      bubble_ex = 1'b0;
      flush_if  = 1'b0;
      flush_id  = 1'b0;
      md_start  = 1'b0;
      md_abort  = 1'b0;

      case (state)
         RUN: begin
            if (hz.br_taken) begin
               flush_if  = 1'b1;
               flush_id  = 1'b1;
               bubble_ex = 1'b1;
               if (FLUSH_LEN > 1) begin
                  state_nx = FLUSH;
                  cnt_nx   = FLUSH_INIT;
               end
            end else if (load_use) begin
               stall_if  = 1'b1;
               stall_id  = 1'b1;
               bubble_ex = 1'b1;
            end else if (hz.id_valid && hz.id_is_md) begin
               md_start = 1'b1;
               stall_if = 1'b1;
               stall_id = 1'b1;
               cnt_nx   = '0;
               state_nx = MD_BUSY;
            end
         end

         FLUSH: begin
            flush_if = 1'b1;
            if (cnt <= 8'd1) begin
               state_nx = RUN;
               cnt_nx   = '0;
            end else begin
               cnt_nx = cnt - 8'd1;
            end
         end

         MD_BUSY: begin
            if (hz.md_done) begin
               state_nx = RUN;
               cnt_nx   = '0;
            end else begin
               stall_if  = 1'b1;
               stall_id  = 1'b1;
               bubble_ex = 1'b1;
               if (cnt == MD_LAST) begin
                  md_abort = 1'b1;
                  state_nx = RUN;
                  cnt_nx   = '0;
               end else begin
                  cnt_nx = cnt + 8'd1;
               end
            end
         end

         default: begin
            state_nx = RUN;
            cnt_nx   = '0;
         end
      endcase

      // Reset silences every control in the reset cycle itself, so an MD op
      // interrupted by reset never sees an abort pulse.
      if (rst) begin
         stall_if  = 1'b0;
         stall_id  = 1'b0;
         bubble_ex = 1'b0;
         flush_if  = 1'b0;
         flush_id  = 1'b0;
         md_start  = 1'b0;
         md_abort  = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         stall_cnt <= '0;
         flush_cnt <= '0;
      end else begin
         if (stall_if && (stall_cnt != '1))
            stall_cnt <= stall_cnt + 32'd1;
         if (flush_if && (flush_cnt != '1))
            flush_cnt <= flush_cnt + 32'd1;
      end
   end

   assign hz.stall_if  = stall_if;
   assign hz.stall_id  = stall_id;
   assign hz.bubble_ex = bubble_ex;
   assign hz.flush_if  = flush_if;
   assign hz.flush_id  = flush_id;
   assign hz.md_start  = md_start;
   assign hz.md_abort  = md_abort;
   assign hz.stall_cnt = stall_cnt;
   assign hz.flush_cnt = flush_cnt;

endmodule
